// File: rtl/codigojunto_pkg.sv
// Shared definitions for the codigojunto election tally block.
// Holds the width constants and the identifier, popular-vote and
// jury-tally types used by the top level and the jury_tally sub-module.
package codigojunto_pkg;

  localparam int ID_W   = 2;
  localparam int VOTE_W = 6;
  localparam int CNT_W  = 3;

  typedef logic [ID_W-1:0]   cand_id_t;
  typedef logic [VOTE_W-1:0] vote_t;
  typedef logic [CNT_W-1:0]  tally_t;

endpackage

// File: rtl/codigojunto_jury_tally.sv
// jury_tally: counts how many of the four jurors chose a given identifier.
// Ports:
//   id          identifier of the candidate slot being tallied
//   j1..j4      identifiers chosen by the four jurors
//   count       number of jurors whose choice equals id (0..4)
module jury_tally
  import codigojunto_pkg::*;
(
  input  logic [ID_W-1:0]  id,
  input  logic [ID_W-1:0]  j1,
  input  logic [ID_W-1:0]  j2,
  input  logic [ID_W-1:0]  j3,
  input  logic [ID_W-1:0]  j4,
  output logic [CNT_W-1:0] count
);

  // Each matching juror adds one; the 3-bit result holds the worst case of 4.
  always_comb begin
    count = '0;
    if (j1 == id) count = count + tally_t'(1);
    if (j2 == id) count = count + tally_t'(1);
    if (j3 == id) count = count + tally_t'(1);
    if (j4 == id) count = count + tally_t'(1);
  end

endmodule

// File: rtl/codigojunto.sv
// codigojunto: election tally for a 4-candidate contest.
// Picks the popular-vote winner among slots A..D and the jury winner among
// slots A..C, loading all results into registers on an evaluate strobe.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   A, B, C, D            candidate identifiers held in each slot
//   VA, VB, VC, VD        unsigned popular votes for each slot
//   J1..J4                identifiers chosen by the four jurors
//   paraoif               evaluate strobe; outputs load when it is 1
//   Candidato1            identifier of the popular-vote winner
//   Candidato2            {valid, jury-winner identifier}
//   contagem_A/B/C        juror match counts for slots A, B and C
module codigojunto
  import codigojunto_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   A,
  input  logic [ID_W-1:0]   B,
  input  logic [ID_W-1:0]   C,
  input  logic [ID_W-1:0]   D,
  input  logic [VOTE_W-1:0] VA,
  input  logic [VOTE_W-1:0] VB,
  input  logic [VOTE_W-1:0] VC,
  input  logic [VOTE_W-1:0] VD,
  input  logic [ID_W-1:0]   J1,
  input  logic [ID_W-1:0]   J2,
  input  logic [ID_W-1:0]   J3,
  input  logic [ID_W-1:0]   J4,
  input  logic              paraoif,
  output logic [ID_W-1:0]   Candidato1,
  output logic [ID_W:0]     Candidato2,
  output logic [CNT_W-1:0]  contagem_A,
  output logic [CNT_W-1:0]  contagem_B,
  output logic [CNT_W-1:0]  contagem_C
);

  tally_t   count_a, count_b, count_c;
  cand_id_t pop_id;
  vote_t    pop_max;
  logic [ID_W:0] jury_result;

  jury_tally u_tally_a (.id(A), .j1(J1), .j2(J2), .j3(J3), .j4(J4), .count(count_a));
  jury_tally u_tally_b (.id(B), .j1(J1), .j2(J2), .j3(J3), .j4(J4), .count(count_b));
  jury_tally u_tally_c (.id(C), .j1(J1), .j2(J2), .j3(J3), .j4(J4), .count(count_c));

  // Popular argmax: a later slot only takes over on a strictly larger count,
  // so ties stay with the earlier slot (A > B > C > D).
  always_comb begin
    pop_id  = A;
    pop_max = VA;
    if (VB > pop_max) begin
      pop_id  = B;
      pop_max = VB;
    end
    if (VC > pop_max) begin
      pop_id  = C;
      pop_max = VC;
    end
    if (VD > pop_max) begin
      pop_id  = D;
      pop_max = VD;
    end
  end

  // Jury argmax: only a strict, unique maximum yields a valid winner.
  // All-zero counts tie at zero and therefore report no winner.
  always_comb begin
    jury_result = '0;
    if ((count_a > count_b) && (count_a > count_c)) begin
      jury_result = {1'b1, A};
    end else if ((count_b > count_a) && (count_b > count_c)) begin
      jury_result = {1'b1, B};
    end else if ((count_c > count_a) && (count_c > count_b)) begin
      jury_result = {1'b1, C};
    end
  end

  // Result registers: load everything together on the strobe, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Candidato1 <= '0;
      Candidato2 <= '0;
      contagem_A <= '0;
      contagem_B <= '0;
      contagem_C <= '0;
    end else if (paraoif) begin
      Candidato1 <= pop_id;
      Candidato2 <= jury_result;
      contagem_A <= count_a;
      contagem_B <= count_b;
      contagem_C <= count_c;
    end
  end

endmodule

// File: tb/tb_codigojunto.sv
// Self-checking bench for codigojunto: a reference model computes the
// expected result when a strobe is driven, queues it, and the queue is
// popped and compared once the registered outputs have updated.
module tb_codigojunto;
  import codigojunto_pkg::*;

  typedef struct packed {
    logic [1:0] c1;
    logic [2:0] c2;
    logic [2:0] ca;
    logic [2:0] cb;
    logic [2:0] cc;
  } result_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] A, B, C, D, J1, J2, J3, J4;
  logic [5:0] VA, VB, VC, VD;
  logic paraoif = 1'b0;
  logic [1:0] Candidato1;
  logic [2:0] Candidato2, contagem_A, contagem_B, contagem_C;

  result_t exp_q[$];
  result_t last_result;
  int total = 0;
  int bad = 0;

  codigojunto dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .B(B), .C(C), .D(D),
    .VA(VA), .VB(VB), .VC(VC), .VD(VD),
    .J1(J1), .J2(J2), .J3(J3), .J4(J4),
    .paraoif(paraoif),
    .Candidato1(Candidato1), .Candidato2(Candidato2),
    .contagem_A(contagem_A), .contagem_B(contagem_B), .contagem_C(contagem_C)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input result_t e);
    checkOutput({tag, ".Candidato1"}, 32'(Candidato1), 32'(e.c1));
    checkOutput({tag, ".Candidato2"}, 32'(Candidato2), 32'(e.c2));
    checkOutput({tag, ".contagem_A"}, 32'(contagem_A), 32'(e.ca));
    checkOutput({tag, ".contagem_B"}, 32'(contagem_B), 32'(e.cb));
    checkOutput({tag, ".contagem_C"}, 32'(contagem_C), 32'(e.cc));
  endtask

  // Reference model built from the current input values.
  function automatic result_t model();
    logic [1:0] ids[4];
    logic [5:0] votes[4];
    logic [1:0] jur[4];
    int cnt[3];
    int best, top, ntop, topidx;
    result_t r;
    ids   = '{A, B, C, D};
    votes = '{VA, VB, VC, VD};
    jur   = '{J1, J2, J3, J4};
    best = 0;
    for (int i = 1; i < 4; i++)
      if (votes[i] > votes[best]) best = i;
    for (int s = 0; s < 3; s++) begin
      cnt[s] = 0;
      for (int j = 0; j < 4; j++)
        if (jur[j] == ids[s]) cnt[s]++;
    end
    top = 0;
    for (int s = 0; s < 3; s++)
      if (cnt[s] > top) top = cnt[s];
    ntop = 0;
    topidx = 0;
    for (int s = 0; s < 3; s++)
      if (cnt[s] == top) begin
        ntop++;
        topidx = s;
      end
    r.c1 = ids[best];
    r.c2 = (top > 0 && ntop == 1) ? {1'b1, ids[topidx]} : 3'b000;
    r.ca = 3'(cnt[0]);
    r.cb = 3'(cnt[1]);
    r.cc = 3'(cnt[2]);
    return r;
  endfunction

  task automatic setInputs(input logic [1:0] a, b, c, d,
                           input logic [5:0] va, vb, vc, vd,
                           input logic [1:0] j1, j2, j3, j4);
    A = a; B = b; C = c; D = d;
    VA = va; VB = vb; VC = vc; VD = vd;
    J1 = j1; J2 = j2; J3 = j3; J4 = j4;
  endtask

  task automatic randomInputs();
    setInputs(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
              2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
  endtask

  // Drive one election with a strobe, queue its expected result, then pop
  // and compare once the registers have loaded.
  task automatic applyStimulus(input string tag,
                               input logic [1:0] a, b, c, d,
                               input logic [5:0] va, vb, vc, vd,
                               input logic [1:0] j1, j2, j3, j4);
    result_t e;
    @(negedge clk);
    setInputs(a, b, c, d, va, vb, vc, vd, j1, j2, j3, j4);
    paraoif = 1'b1;
    exp_q.push_back(model());
    @(posedge clk);
    #1;
    paraoif = 1'b0;
    if (exp_q.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkResult(tag, e);
      last_result = e;
    end
  endtask

  initial begin
    result_t zero;
    zero = '0;

    // Reset held with a strobe active: nothing may load.
    randomInputs();
    paraoif = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResult("reset", zero);
    @(negedge clk);
    rst_n = 1'b1;
    paraoif = 1'b0;
    randomInputs();
    repeat (3) @(posedge clk);
    #1;
    checkResult("post_reset", zero);

    // Nominal election, also checked against hand-derived constants.
    applyStimulus("nominal", 2'b00, 2'b01, 2'b10, 2'b11, 6'd17, 6'd15, 6'd15, 6'd53,
                  2'b01, 2'b01, 2'b10, 2'b00);
    checkOutput("nominal_c1_const", 32'(Candidato1), 32'd3);
    checkOutput("nominal_c2_const", 32'(Candidato2), 32'd5);
    checkOutput("nominal_cb_const", 32'(contagem_B), 32'd2);

    // Popular tie between B and C resolves to B.
    applyStimulus("pop_tie", 2'b00, 2'b01, 2'b10, 2'b11, 6'd20, 6'd40, 6'd40, 6'd5,
                  2'b01, 2'b01, 2'b10, 2'b00);
    checkOutput("pop_tie_const", 32'(Candidato1), 32'd1);

    // All popular votes zero gives slot A.
    applyStimulus("pop_zero", 2'b10, 2'b01, 2'b00, 2'b11, 6'd0, 6'd0, 6'd0, 6'd0,
                  2'b10, 2'b10, 2'b10, 2'b01);
    checkOutput("pop_zero_const", 32'(Candidato1), 32'd2);

    // Jury tie 2/2/0.
    applyStimulus("jury_tie", 2'b00, 2'b01, 2'b10, 2'b11, 6'd1, 6'd2, 6'd3, 6'd4,
                  2'b00, 2'b00, 2'b01, 2'b01);
    checkOutput("jury_tie_const", 32'(Candidato2), 32'd0);

    // Every juror picks D: no tally, no winner.
    applyStimulus("jury_d", 2'b00, 2'b01, 2'b10, 2'b11, 6'd63, 6'd2, 6'd3, 6'd4,
                  2'b11, 2'b11, 2'b11, 2'b11);
    checkOutput("jury_d_const", 32'(contagem_A + contagem_B + contagem_C), 32'd0);

    // Unanimous jury for C with duplicate slot identifiers A==B.
    applyStimulus("jury_c4", 2'b01, 2'b01, 2'b10, 2'b00, 6'd9, 6'd9, 6'd10, 6'd10,
                  2'b10, 2'b10, 2'b10, 2'b10);
    checkOutput("jury_c4_const", 32'(Candidato2), 32'd6);

    // Hold: inputs churn with no strobe, outputs must not move.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      randomInputs();
      @(posedge clk);
      #1;
      checkResult("hold", last_result);
    end
    applyStimulus("after_hold", 2'b11, 2'b10, 2'b01, 2'b00, 6'd5, 6'd50, 6'd7, 6'd8,
                  2'b10, 2'b10, 2'b11, 2'b00);

    // Random elections.
    for (int n = 0; n < 30; n++) begin
      applyStimulus("random", 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                    2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end

    // Async reset between edges after a valid nonzero result.
    applyStimulus("pre_async", 2'b00, 2'b01, 2'b10, 2'b11, 6'd17, 6'd15, 6'd15, 6'd53,
                  2'b01, 2'b01, 2'b10, 2'b00);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResult("async_reset", zero);
    paraoif = 1'b1;
    @(posedge clk);
    #1;
    checkResult("reset_over_strobe", zero);
    paraoif = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
